// File: rtl/vrp_req_lcrd_ctrl_pkg.sv
// Shared types and constants for the L1D downstream request link-credit controller.
package vrp_req_lcrd_ctrl_pkg;

  localparam int         L1D_LCRD_MAX       = 15;
  localparam logic [5:0] L1D_OPC_LCRDRETURN = 6'h0;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [47:0] addr;
  } pack_req_flit;

  typedef enum logic [1:0] {
    STOP,
    ACTIVATE,
    RUN,
    DEACTIVATE
  } lcrd_state_e;

  function automatic pack_req_flit lcrd_return_flit();
    pack_req_flit f;
    f        = '0;
    f.opcode = L1D_OPC_LCRDRETURN;
    return f;
  endfunction

endpackage

// File: rtl/vrp_req_lcrd_ctrl_if.sv
// Request channel bundle: upstream arbiter handshake, downstream TX flit port and link activation pair.
interface vrp_req_lcrd_ctrl_if;
  import vrp_req_lcrd_ctrl_pkg::*;

  logic         txla_req;
  logic         rxla_ack;
  logic         in_vld;
  logic         in_rdy;
  pack_req_flit in_flit;
  logic         out_flitpend;
  logic         out_flitv;
  pack_req_flit out_flit;
  logic         out_lcrdv;

  modport master (
    output txla_req, in_rdy, out_flitpend, out_flitv, out_flit,
    input  rxla_ack, in_vld, in_flit, out_lcrdv
  );

  modport slave (
    input  txla_req, in_rdy, out_flitpend, out_flitv, out_flit,
    output rxla_ack, in_vld, in_flit, out_lcrdv
  );

endinterface

// File: rtl/vrp_req_lcrd_ctrl_crd.sv
// Saturating up/down credit counter; ovf flags an increment attempted at MAX.
module vrp_crd_counter #(
  parameter int MAX = 15,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign ovf = inc && !dec && (cnt == MAX_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != MAX_V) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/vrp_req_lcrd_ctrl.sv
// L-credit and link activation controller for the L1D downstream request channel.
// Optional build macro VRP_LCRD_BYPASS_EN: in RUN a credit arriving this cycle may be used at once.
module vrp_req_lcrd_ctrl
  import vrp_req_lcrd_ctrl_pkg::*;
#(
  parameter  int MAX_CRD = L1D_LCRD_MAX,
  localparam int CRD_W   = $clog2(MAX_CRD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 link_en,
  vrp_req_lcrd_ctrl_if.master  bus,
  output logic [CRD_W-1:0]     crd_cnt,
  output logic                 link_up,
  output logic                 crd_err
);

  lcrd_state_e state;
  logic cnt_nz, crd_avail, accept, ret_send, consume;
  logic crd_inc, crd_ovf, lcrdv_illegal;

  assign cnt_nz = (crd_cnt != '0);

`ifdef VRP_LCRD_BYPASS_EN
  assign crd_avail = cnt_nz || bus.out_lcrdv;
`else
  assign crd_avail = cnt_nz;
`endif

  assign bus.in_rdy    = (state == RUN) && crd_avail;
  assign accept        = bus.in_vld && bus.in_rdy;
  assign ret_send      = (state == DEACTIVATE) && cnt_nz;
  assign consume       = accept || ret_send;
  assign crd_inc       = bus.out_lcrdv && ((state == RUN) || (state == DEACTIVATE));
  assign lcrdv_illegal = bus.out_lcrdv && !crd_inc;

  always_comb begin
    bus.out_flitpend = 1'b0;
    case (state)
      RUN:        bus.out_flitpend = bus.in_vld && crd_avail;
      DEACTIVATE: bus.out_flitpend = cnt_nz;
      default:    bus.out_flitpend = 1'b0;
    endcase
  end

  vrp_crd_counter #(
    .MAX (MAX_CRD),
    .W   (CRD_W)
  ) u_crd (
    .clk (clk),
    .rst (rst),
    .inc (crd_inc),
    .dec (consume),
    .cnt (crd_cnt),
    .ovf (crd_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STOP;
      bus.txla_req  <= 1'b0;
      link_up       <= 1'b0;
      bus.out_flitv <= 1'b0;
      bus.out_flit  <= '0;
      crd_err       <= 1'b0;
    end else begin
      bus.out_flitv <= consume;
      bus.out_flit  <= accept ? bus.in_flit : (ret_send ? lcrd_return_flit() : '0);
      if (crd_ovf || lcrdv_illegal) crd_err <= 1'b1;
      case (state)
        STOP: begin
          if (link_en) begin
            state        <= ACTIVATE;
            bus.txla_req <= 1'b1;
          end
        end
        ACTIVATE: begin
          if (!link_en) begin
            state        <= DEACTIVATE;
            bus.txla_req <= 1'b0;
          end else if (bus.rxla_ack) begin
            state   <= RUN;
            link_up <= 1'b1;
          end
        end
        RUN: begin
          if (!link_en) begin
            state        <= DEACTIVATE;
            bus.txla_req <= 1'b0;
            link_up      <= 1'b0;
          end
        end
        DEACTIVATE: begin
          // a credit landing this cycle must still be returned before stopping
          if (!cnt_nz && !bus.out_lcrdv && !bus.rxla_ack) state <= STOP;
        end
        default: state <= STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_vrp_req_lcrd_ctrl.sv
// Randomized + directed bench for vrp_req_lcrd_ctrl against a cycle-level behavioural model.
module tb_vrp_req_lcrd_ctrl;
  import vrp_req_lcrd_ctrl_pkg::*;

  localparam int MAXC     = 15;
  localparam int MS_STOP  = 0;
  localparam int MS_ACT   = 1;
  localparam int MS_RUN   = 2;
  localparam int MS_DEACT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       link_en;
  logic [3:0] crd_cnt;
  logic       link_up;
  logic       crd_err;

  vrp_req_lcrd_ctrl_if bus ();

  vrp_req_lcrd_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .link_en (link_en),
    .bus     (bus),
    .crd_cnt (crd_cnt),
    .link_up (link_up),
    .crd_err (crd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_flitv = 0;
  bit byp;

  int           m_st, m_cnt;
  bit           m_txla, m_up, m_err, m_flitv;
  pack_req_flit m_flit;

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic pack_req_flit rand_flit();
    pack_req_flit f;
    f.qos    = 4'($urandom);
    f.tgt_id = 7'($urandom);
    f.src_id = 7'($urandom);
    f.txn_id = 8'($urandom);
    f.opcode = 6'($urandom_range(1, 63));
    f.addr   = {16'($urandom), 32'($urandom)};
    return f;
  endfunction

  task automatic drive(input bit le, input bit ack, input bit vld, input bit lcrd);
    link_en       = le;
    bus.rxla_ack  = ack;
    bus.in_vld    = vld;
    bus.out_lcrdv = lcrd;
    bus.in_flit   = rand_flit();
  endtask

  task automatic model_reset();
    m_st = MS_STOP; m_cnt = 0;
    m_txla = 0; m_up = 0; m_err = 0; m_flitv = 0; m_flit = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit lc, usable, acc, ret;
    int pre_cnt, nxt;
    @(negedge clk);
    lc     = bus.out_lcrdv;
    usable = (m_cnt > 0) || (byp && lc);
    check_val("in_rdy", bus.in_rdy, (m_st == MS_RUN) && usable);
    check_val("flitpend", bus.out_flitpend,
              ((m_st == MS_RUN) && bus.in_vld && usable) || ((m_st == MS_DEACT) && (m_cnt > 0)));
    acc     = (m_st == MS_RUN) && usable && bus.in_vld;
    ret     = (m_st == MS_DEACT) && (m_cnt > 0);
    pre_cnt = m_cnt;
    m_flitv = acc || ret;
    m_flit  = acc ? bus.in_flit : '0;
    if (lc && !((m_st == MS_RUN) || (m_st == MS_DEACT))) m_err = 1;
    else begin
      m_cnt = m_cnt + int'(lc) - int'(acc || ret);
      if (m_cnt > MAXC) begin m_cnt = MAXC; m_err = 1; end
    end
    nxt = m_st;
    case (m_st)
      MS_STOP: if (link_en) nxt = MS_ACT;
      MS_ACT:  if (!link_en) nxt = MS_DEACT; else if (bus.rxla_ack) nxt = MS_RUN;
      MS_RUN:  if (!link_en) nxt = MS_DEACT;
      default: if (pre_cnt == 0 && !lc && !bus.rxla_ack) nxt = MS_STOP;
    endcase
    m_st   = nxt;
    m_txla = (nxt == MS_ACT) || (nxt == MS_RUN);
    m_up   = (nxt == MS_RUN);
    @(posedge clk); #1;
    obs_flitv += int'(bus.out_flitv);
    check_val("txla_req", bus.txla_req, m_txla);
    check_val("link_up", link_up, m_up);
    check_val("out_flitv", bus.out_flitv, m_flitv);
    check_val("out_flit", bus.out_flit, m_flit);
    check_val("crd_cnt", crd_cnt, m_cnt[3:0]);
    check_val("crd_err", crd_err, m_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_val("rst_txla", bus.txla_req, 1'b0);
    check_val("rst_flitv", bus.out_flitv, 1'b0);
    check_val("rst_flit", bus.out_flit, 80'h0);
    check_val("rst_cnt", crd_cnt, 4'd0);
    check_val("rst_err", crd_err, 1'b0);
    check_val("rst_up", link_up, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic activate();
    drive(1, 0, 0, 0); step();
    drive(1, 1, 0, 0); step();
  endtask

  initial begin
`ifdef VRP_LCRD_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rst = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();
    do_reset();

    // activation with ack three cycles after link_en
    drive(1, 0, 0, 0); step();
    check_val("act_txla", bus.txla_req, 1'b1);
    step(); step();
    drive(1, 1, 0, 0); step();
    check_val("act_up", link_up, 1'b1);

    // two credits, four back-to-back flits: only two go out
    repeat (2) begin drive(1, 1, 0, 1); step(); end
    check_val("gate_cnt2", crd_cnt, 4'd2);
    obs_flitv = 0;
    repeat (4) begin drive(1, 1, 1, 0); step(); end
    drive(1, 1, 0, 0); step();
    check_val("gate_sent", obs_flitv, 2);
    check_val("gate_cnt0", crd_cnt, 4'd0);

    // credit arrival and accept in the same cycle
    drive(1, 1, 0, 1); step();
    drive(1, 1, 1, 1); step();
    check_val("simul_cnt", crd_cnt, 4'd1);
    check_val("simul_flitv", bus.out_flitv, 1'b1);
    drive(1, 1, 1, 0); step();
    drive(1, 1, 0, 0); step();

    // saturation
    repeat (15) begin drive(1, 1, 0, 1); step(); end
    check_val("sat_cnt15", crd_cnt, 4'd15);
    check_val("sat_err0", crd_err, 1'b0);
    drive(1, 1, 0, 1); step();
    check_val("sat_cnt", crd_cnt, 4'd15);
    check_val("sat_err1", crd_err, 1'b1);

    // deactivation drains three credits as LCrdReturn flits
    do_reset();
    activate();
    repeat (3) begin drive(1, 1, 0, 1); step(); end
    drive(0, 1, 0, 0); step();
    check_val("deact_txla", bus.txla_req, 1'b0);
    obs_flitv = 0;
    repeat (3) begin drive(0, 1, 0, 0); step(); end
    check_val("deact_returns", obs_flitv, 3);
    check_val("deact_cnt", crd_cnt, 4'd0);
    drive(0, 0, 0, 0); step(); step();
    check_val("deact_up", link_up, 1'b0);
    check_val("deact_txla2", bus.txla_req, 1'b0);

    // same-cycle credit and request with empty pool
    do_reset();
    activate();
    drive(1, 1, 1, 1); step();
    check_val("byp_cnt", crd_cnt, byp ? 4'd0 : 4'd1);
    check_val("byp_flitv", bus.out_flitv, byp);
    drive(1, 1, 0, 0); step();

    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit le, ack, lc;
      if ($urandom_range(0, 499) == 0) do_reset();
      le  = ($urandom_range(0, 39) == 0) ? !link_en : link_en;
      ack = ($urandom_range(0, 3) == 0) ? m_txla : bus.rxla_ack;
      if ((m_st == MS_RUN) || (m_st == MS_DEACT)) lc = ($urandom_range(0, 9) < 3);
      else lc = ($urandom_range(0, 49) == 0);
      drive(le, ack, 1'($urandom_range(0, 1)), lc);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vrp_req_lcrd_ctrl.md
Name: vrp_req_lcrd_ctrl

Overview:
- Link-layer credit and activation controller for the L1D downstream request channel.
- Sits between the MSHR request arbiter (upstream, one granted flit per handshake) and the downstream interconnect TX port.
- Runs the link activation/deactivation handshake and tracks L-credits received on lcrdv; a flit is sent only when a credit is held.
- On deactivation, returns every held credit as an LCrdReturn flit.

Parameters:
- MAX_CRD, 15, maximum L-credits held; counter saturates here.
- CRD_W, $clog2(MAX_CRD+1), credit counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- link_en  in  1  request link up (1) / down (0); level, from config.
- txla_req  out  1  link activation request to downstream.
- rxla_ack  in  1  link activation acknowledge from downstream.
- in_vld  in  1  upstream arbiter has a flit.
- in_rdy  out  1  flit accepted this cycle.
- in_flit  in  $bits(pack_req_flit)  flit from arbiter.
- out_flitpend  out  1  flit may be sent next cycle.
- out_flitv  out  1  flit valid.
- out_flit  out  $bits(pack_req_flit)  flit to downstream.
- out_lcrdv  in  1  one L-credit granted by downstream.
- crd_cnt  out  CRD_W  current credit count.
- link_up  out  1  state==RUN.
- crd_err  out  1  sticky protocol error.

Behaviour:
- Reset values: txla_req=0, out_flitv=0, out_flit=0, crd_cnt=0, crd_err=0, state=STOP. Reset mid-operation discards all held credits.
- STOP:
  - txla_req=0.
  - link_en=1 -> ACTIVATE.
- ACTIVATE:
  - txla_req=1.
  - rxla_ack=1 -> RUN.
  - link_en falling before ack -> DEACTIVATE.
- RUN:
  - txla_req=1.
  - in_rdy = in_vld-independent (crd_cnt!=0).
  - Accept on in_vld&&in_rdy: next cycle out_flitv=1 and out_flit=in_flit (1-cycle registered latency).
  - Otherwise next cycle out_flitv=0 and out_flit=0.
  - out_flitpend = in_vld && crd_cnt!=0.
  - link_en=0 -> DEACTIVATE; a flit accepted in that same cycle is still sent.
- DEACTIVATE:
  - txla_req=0, in_rdy=0.
  - Each cycle with crd_cnt!=0, send one LCrdReturn flit next cycle: Opcode=6'h0, all other fields 0, out_flitv=1. This consumes one credit.
  - out_flitpend = (crd_cnt!=0).
  - crd_cnt==0 && rxla_ack==0 -> STOP.
- Credit arithmetic, per cycle:
  - crd_cnt_next = crd_cnt + out_lcrdv - consume.
  - consume = flit accept (RUN) or return send (DEACTIVATE).
  - Simultaneous lcrdv and consume -> count unchanged.
- Boundary conditions:
  - lcrdv at crd_cnt==MAX_CRD with no consume -> count holds at MAX_CRD, crd_err set.
  - lcrdv in STOP or ACTIVATE -> ignored, crd_err set.
  - lcrdv in DEACTIVATE is legal and counted; that credit is then returned.
  - crd_err clears only on rst.

Optional Feature:
- Macro: VRP_LCRD_BYPASS_EN.
- Defined:
  - In RUN, in_rdy = (crd_cnt!=0) || out_lcrdv, so a credit arriving this cycle is consumed immediately.
  - out_flitpend uses the same term.
  - crd_cnt stays 0 in that case.
- Undefined: credit usable only from the cycle after it is counted.

Decomposition:
- l1d_package holds:
  - pack_req_flit (existing).
  - Enum lcrd_state_e {STOP, ACTIVATE, RUN, DEACTIVATE}.
  - Constants L1D_OPC_LCRDRETURN=6'h0 and L1D_LCRD_MAX=15.
- Natural sub-module: vrp_crd_counter, a saturating up/down counter with overflow flag, reusable for the response channel.

Test Plan:
- Activation: link_en=1, rxla_ack after 3 cycles -> txla_req=1 from cycle 1; link_up=1 one cycle after ack; in_rdy=0 while crd_cnt=0.
- Credit gating: RUN, 2 lcrdv pulses, in_vld held for 4 cycles with flits A,B,C,D -> only A and B accepted; out_flitv on the cycles after acceptance; crd_cnt goes 2->1->0.
- Simultaneous event: crd_cnt=1, lcrdv and accept in the same cycle -> crd_cnt stays 1; flit sent next cycle.
- Saturation: 16 lcrdv pulses with no traffic -> crd_cnt=15, crd_err=1 after the 16th pulse.
- Deactivation: crd_cnt=3, link_en=0 -> txla_req=0; 3 consecutive LCrdReturn flits (Opcode 0); crd_cnt reaches 0; after rxla_ack drops, state STOP and link_up=0.
- Bypass (macro defined): RUN, crd_cnt=0, in_vld and lcrdv in the same cycle -> in_rdy=1; flit out next cycle; crd_cnt stays 0. Macro undefined -> in_rdy=0 that cycle.
